// File: rtl/otp_pkg.sv
// rtl/otp_pkg.sv - shared constants and helpers for the one-time-pad buffer
package otp_pkg;

  localparam int PAD_W         = 8;
  localparam int DEPTH_DEFAULT = 16;

  localparam logic [PAD_W-1:0] ZERO_PAD = '0;

  // Pointer width for a power-of-two slot count; never below one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/otp_pad_mem.sv
// rtl/otp_pad_mem.sv - DEPTH x PAD_W pad register file with write, read-and-zeroise and clear-all
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (zeroises every slot)
//   clr                synchronous zeroise of every slot, overrides write and read
//   wr_en/addr/data    write port
//   rd_en/addr         read port; rd_en zeroises the addressed slot on the edge
//   rd_data            combinational contents of slot[rd_addr]
module otp_pad_mem
  import otp_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int PAD_W  = otp_pkg::PAD_W,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PAD_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PAD_W-1:0]  rd_data
);

  logic [PAD_W-1:0] slots_q [DEPTH];
  logic [PAD_W-1:0] slots_d [DEPTH];

  always_comb begin
    slots_d = slots_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) slots_d[i] = '0;
    end else begin
      // The parent never writes and consumes the same slot together; the
      // write is ordered last so it would win if it ever did.
      if (rd_en) slots_d[rd_addr] = '0;
      if (wr_en) slots_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
    end else begin
      slots_q <= slots_d;
    end
  end

  assign rd_data = slots_q[rd_addr];

endmodule

// File: rtl/otp_pad_buffer.sv
// rtl/otp_pad_buffer.sv - one-time-pad key buffer issuing each pad byte exactly once
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ena                    tile enable; when low all state holds and the output pulse drops
//   key_valid/key_data     pad byte load, accepted when key_ready
//   key_ready              buffer not full
//   clear                  synchronous flush and zeroise (highest priority, gated by ena)
//   pad_req                request one pad byte
//   pad_data/pad_valid     registered pad byte, one-cycle pulse, zero when not valid
//   count/empty/full       fill level and flags
//   underflow              sticky: pad_req seen while empty
module otp_pad_buffer
  import otp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PAD_W = otp_pkg::PAD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     key_valid,
  input  logic [PAD_W-1:0]         key_data,
  output logic                     key_ready,
  input  logic                     clear,
  input  logic                     pad_req,
  output logic [PAD_W-1:0]         pad_data,
  output logic                     pad_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              underflow_q, underflow_d;
  logic              pad_valid_q, pad_valid_d;
  logic [PAD_W-1:0]  pad_data_q, pad_data_d;

  logic             do_clear, do_push, do_pop, do_under;
  logic [PAD_W-1:0] rd_data;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_CNT);
  assign key_ready = ~full;

  // Flush outranks everything, so push/pop are suppressed on a clear edge.
  assign do_clear = ena & clear;
  assign do_push  = ena & ~clear & key_valid & ~full;
  assign do_pop   = ena & ~clear & pad_req & ~empty;
  assign do_under = ena & ~clear & pad_req & empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    // Output drops to zero on any cycle without a pop so no key lingers.
    pad_valid_d = 1'b0;
    pad_data_d  = '0;

    if (do_clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (do_pop) begin
        rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
        pad_valid_d = 1'b1;
        pad_data_d  = rd_data;
      end
      if (do_under) underflow_d = 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      pad_valid_q <= 1'b0;
      pad_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      pad_valid_q <= pad_valid_d;
      pad_data_q  <= pad_data_d;
    end
  end

  otp_pad_mem #(
    .DEPTH  (DEPTH),
    .PAD_W  (PAD_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (do_clear),
    .wr_en   (do_push),
    .wr_addr (wr_ptr_q),
    .wr_data (key_data),
    .rd_en   (do_pop),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign count     = count_q;
  assign underflow = underflow_q;
  assign pad_valid = pad_valid_q;
  assign pad_data  = pad_data_q;

endmodule

// File: doc/otp_pad_buffer.md
Name: otp_pad_buffer

Overview:
Upstream stage of tt_um_otp_encryptor. Holds one-time-pad key bytes loaded from the uio bus and hands exactly one fresh pad byte to the encryptor per plaintext byte. Each pad byte is destroyed (zeroised) the moment it is consumed, so no key byte is ever issued twice. Reports fill level and a sticky underflow error when the encryptor asks for pad and none is left.

Parameters:
DEPTH, 16, number of pad-byte slots; power of two, 2..32.
PAD_W, 8, pad byte width.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; when 0 no push, pop or clear takes effect and all state is held
key_valid  input  1  load strobe for key_data
key_data  input  PAD_W  pad byte to store
key_ready  output  1  buffer can accept a byte (= ~full)
clear  input  1  synchronous flush and zeroise of all slots
pad_req  input  1  encryptor requests one pad byte
pad_data  output  PAD_W  issued pad byte (registered)
pad_valid  output  1  pad_data valid, one-cycle pulse
count  output  $clog2(DEPTH)+1  bytes currently stored
empty  output  1  count == 0
full  output  1  count == DEPTH
underflow  output  1  sticky: pad_req seen while empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - all slots = 0, wr_ptr = rd_ptr = 0, count = 0.
  - pad_data = 0, pad_valid = 0, underflow = 0, key_ready = 1, empty = 1, full = 0.
- Push: on a rising edge with ena & key_valid & key_ready, key_data is written to slot[wr_ptr]. wr_ptr increments mod DEPTH.
- Pop: on a rising edge with ena & pad_req & ~empty:
  - pad_data <= slot[rd_ptr] and pad_valid <= 1. The byte is visible 1 cycle after the request.
  - slot[rd_ptr] <= 0 on the same edge (zeroise).
  - rd_ptr increments mod DEPTH.
- Any cycle without a successful pop: pad_valid <= 0. pad_data <= 0, so a stale key is never left on the output.
- Pop when empty (ena & pad_req & empty): pad_valid stays 0 and underflow <= 1. Underflow clears only on rst_n or clear.
- Simultaneous push and pop:
  - Non-empty and non-full: both happen and count is unchanged.
  - Empty: no bypass. The pop underflows, the push stores, and count becomes 1.
  - Full: key_ready = 0, so the push is ignored and the pop proceeds. key_ready rises the following cycle.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Saturation cannot occur because of gating.
- key_ready, empty and full are combinational from count. Pointers use ADDR_W = $clog2(DEPTH) bits and wrap naturally.
- clear (with ena): synchronous and highest priority. On that edge all slots, pointers, count, underflow, pad_valid and pad_data go to 0. Same-cycle push and pop are discarded.
- ena = 0: everything is held, except that pad_valid and pad_data drop to 0 on the next edge.
- Reset asserted mid-operation: immediate return to reset values, including zeroisation of every slot.

Decomposition:
- Shared package otp_pkg: PAD_W, DEPTH_DEFAULT, ADDR_W function/constant, ZERO_PAD constant.
- Sub-module otp_pad_mem: DEPTH x PAD_W register file.
  - One write port, one read-and-zeroise port, plus a clear-all input.
  - The parent owns pointers, count, flags and output registers.

Test Plan:
- Reset then load 0xA5, 0x3C, 0x7E; pulse pad_req for 3 cycles -> pad_data = 0xA5, 0x3C, 0x7E on cycles +1..+3 with pad_valid high. Final count = 0, empty = 1, and an internal peek shows all slots 0.
- Fill 16 bytes 0x00..0x0F -> full = 1, key_ready = 0. An extra push of 0xFF is ignored. Popping 16 times returns 0x00..0x0F in order, and pointers wrap.
- Empty buffer with pad_req -> pad_valid stays 0, underflow = 1 and stays 1. A later push plus pop works, but underflow stays 1 until clear.
- With count = 5, push and pop together for 4 cycles -> count stays 5 throughout and the bytes pop in FIFO order. When empty, a simultaneous push and pop -> underflow = 1 and count = 1.
- Load 8 bytes, assert clear together with key_valid and pad_req -> count = 0, pad_valid = 0, underflow = 0, and all slots 0.
- Mid-stream ena = 0 for 3 cycles while pad_req and key_valid are high -> no count change and pad_valid = 0. Then an asynchronous rst_n pulse between clock edges -> outputs go to reset values immediately.
